dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data_memory. It shares the memory between port 0 (CPU load/store stage) and port 1 (loader/debug/DMA master) using round-robin arbitration and a req/ack handshake. It also drives the memory's mem_read, mem_write, addr and write_data inputs and registers the read result. An address range check blocks out-of-range accesses.

Parameters:
DEPTH, 1024, number of 32-bit words in the attached data memory; valid word addresses are 0..DEPTH-1
AW, 32, width of requester and memory address buses

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
p0_req  input  1  port 0 access request; held high until p0_ack
p0_we  input  1  port 0: 1 = write, 0 = read
p0_addr  input  AW  port 0 word address
p0_wdata  input  32  port 0 write data
p0_ack  output  1  one-cycle completion pulse for port 0
p0_rdata  output  32  port 0 read data, valid while p0_ack=1
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
err  output  1  one-cycle pulse with ack when the completed access was out of range
mem_read  output  1  to data_memory mem_read
mem_write  output  1  to data_memory mem_write
mem_addr  output  AW  to data_memory addr
mem_wdata  output  32  to data_memory write_data
mem_rdata  input  32  from data_memory read_data (combinational)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE, p0_ack=p1_ack=err=0, p0_rdata=p1_rdata=0, last_grant=1 (port 0 wins first tie). Latched address, write data and we are all 0.
- Memory-side outputs are combinational from state and the latched registers. In every state except ACCESS, mem_read=mem_write=0, mem_addr=0 and mem_wdata=0.
- FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On grant: latch the winner's addr, wdata and we, record the winner in the grant register, compute oor = (addr >= DEPTH), and go to ACCESS.
- ACCESS (exactly one cycle):
  - If !oor: mem_addr = latched addr, mem_wdata = latched wdata, mem_write = we, mem_read = ~we.
  - If oor: mem_read = mem_write = 0, so no memory write occurs.
  - At the clock edge, capture rdata_reg = (!oor && !we) ? mem_rdata : 0. Then go to RESP.
- RESP (exactly one cycle):
  - Assert ack only for the granted port. The granted port's rdata = rdata_reg; the other port's rdata holds its previous value.
  - err = oor.
  - Set last_grant = granted port, then go to IDLE.
- Latency: req sampled high in IDLE at cycle n gives ACCESS at n+1 and ack at n+2. Each access occupies 3 cycles; maximum throughput is 1 access per 3 cycles.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until it sees ack, then drops req on the same edge.
  - req seen high in IDLE after an ack counts as a new request.
  - The losing requester simply waits. Its req is never dropped by the arbiter, and it is served at the next IDLE.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. No port waits more than one other access.
- Changes to a req input while in ACCESS or RESP are ignored.
- Write data is committed by data_memory on the ACCESS→RESP edge. A read after a write from either port returns the new data.
- Reset mid-operation:
  - rst high on the edge that ends ACCESS: the write (if any) still commits, because the memory sees mem_write=1 at that edge. The FSM goes to IDLE and no ack or err is issued.
  - rst in RESP: the ack pulse in that cycle is still visible; the next state is IDLE with last_grant=1.
- Address boundaries: addr = DEPTH-1 is a normal access. addr = DEPTH and any higher value (including 32'hFFFFFFFF) is oor.

Test Plan:
- Reset then port 0 write addr=5, wdata=32'hDEADBEEF: mem_write=1 for exactly 1 cycle at ACCESS, p0_ack 2 cycles after req. A following port 0 read of addr 5 returns p0_rdata=32'hDEADBEEF with p0_ack and err=0.
- Both req asserted in the same cycle right after reset, holding after acks with new addresses: grant order is p0, p1, p0, p1. Exactly one ack per 3 cycles, never both acks high.
- Port 1 write addr=1024 (DEPTH), wdata=32'h1234: mem_write stays 0, p1_ack=1 and err=1 together. A subsequent read of addr 0 is unchanged, and a read of addr=1023 succeeds with err=0.
- Port 1 reads addr 7 (preloaded 32'hA5A5A5A5) while p0 is idle: p1_rdata=32'hA5A5A5A5 on p1_ack, and p0_rdata holds its previous value.
- Assert rst on the ACCESS edge of a port 0 write to addr 9 with 32'h55: no p0_ack, state returns to IDLE. A subsequent read of addr 9 returns 32'h55. After reset, simultaneous requests are granted to port 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer that shares one
// single-port data memory between two req/ack requesters. Each access runs
// IDLE -> ACCESS -> RESP. Addresses at or above DEPTH are reported with err
// and never reach the memory as a read or write strobe.
module dmem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ack,
    output logic [31:0]   p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ack,
    output logic [31:0]   p1_rdata,

    output logic          err,

    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Sequencer state and the transaction latched at grant time.
    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    ack_q, ack_d;
    logic          err_q, err_d;

    // Requester buses gathered into indexable form.
    logic [1:0]          req_v;
    logic [1:0]          we_v;
    logic [AW-1:0]       addr_v [2];
    logic [31:0]         wdata_v [2];
    logic [1:0][31:0]    rdata_v;

    logic                win;
    logic [31:0]         rd_capture;

    assign req_v      = {p1_req, p0_req};
    assign we_v       = {p1_we, p0_we};
    assign addr_v[0]  = p0_addr;
    assign addr_v[1]  = p1_addr;
    assign wdata_v[0] = p0_wdata;
    assign wdata_v[1] = p1_wdata;

    // Writes and out-of-range accesses return zero rather than stale bus data.
    assign rd_capture = (!oor_q && !we_q) ? mem_rdata : 32'h0;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // port that did not win last time.
    always_comb begin
        if (req_v == 2'b11) begin
            win = ~last_grant_q;
        end else begin
            win = req_v[1];
        end
    end

    // Next-state logic for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        oor_d        = oor_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ack_d        = 2'b00;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_v) begin
                    grant_d = win;
                    addr_d  = addr_v[win];
                    wdata_d = wdata_v[win];
                    we_d    = we_v[win];
                    oor_d   = (addr_v[win] >= DEPTH_A);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Ack and err are registered so they appear during RESP.
                ack_d[grant_q] = 1'b1;
                err_d          = oor_q;
                state_d        = RESP;
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; a reset in any state returns to IDLE with port 0
    // favoured on the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    // Per-port read data register: loaded only when that port's access
    // leaves ACCESS, otherwise it keeps the last value returned to the port.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [31:0] rdata_q, rdata_d;

        // Capture the memory result for the granted port.
        always_comb begin
            rdata_d = rdata_q;
            if (state_q == ACCESS && grant_q == 1'(gi)) begin
                rdata_d = rd_capture;
            end
        end

        // Read data register with synchronous clear.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= 32'h0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata_v[gi] = rdata_q;
    end

    // Memory strobes exist only in ACCESS and only for in-range addresses,
    // so an out-of-range write can never corrupt the array.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (state_q == ACCESS && !oor_q) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_write = we_q;
            mem_read  = ~we_q;
        end
    end

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_rdata = rdata_v[0];
    assign p1_rdata = rdata_v[1];
    assign err      = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// two-port traffic, compared cycle by cycle against a transaction-level model
// of the arbitration rules and a reference copy of the memory contents.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack, err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Power-up contents of the attached memory.
    function automatic logic [31:0] init_val(input int i);
        if (i == 7) return 32'hA5A5A5A5;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    // Attached data memory: combinational read, write on the rising edge.
    logic [31:0] hmem [DEPTH];
    bit          hwritten [DEPTH];
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ?
                       (hwritten[mem_addr[9:0]] ? hmem[mem_addr[9:0]] : init_val(int'(mem_addr[9:0])))
                       : 32'h0;
    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'(DEPTH)) begin
            hmem[mem_addr[9:0]]     <= mem_wdata;
            hwritten[mem_addr[9:0]] <= 1'b1;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          m_phase = 0;   // 0 idle, 1 memory access cycle, 2 response cycle
    int          m_last  = 1;
    int          m_gnt   = 0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_we    = 1'b0;
    logic        m_oor   = 1'b0;
    logic [31:0] exp_rd [2];

    bit          saw_ack [2];
    logic [31:0] saw_rd [2];
    logic        saw_err [2];
    int          ack_order [$];
    int          mode = 0;      // 0 manual, 1 refill on ack, 2 random traffic

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 32'd1023;
            1:       return 32'd1024;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom;
            default: return 32'($urandom_range(16, 31));
        endcase
    endfunction

    task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
        end
    endtask

    // One clock: advance the model over the edge just taken, compare, then
    // let the requesters react to what they saw.
    task automatic cycle();
        bit e_ack0, e_ack1, e_err, e_mw, e_mr;
        @(negedge clk);
        if (rst) begin
            if (m_phase == 1 && !m_oor && m_we) ref_mem[m_addr[9:0]] = m_wdata;
            m_phase = 0; m_last = 1; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        end else begin
            case (m_phase)
                0: begin
                    if (p0_req || p1_req) begin
                        if (p0_req && p1_req) m_gnt = (m_last == 0) ? 1 : 0;
                        else                  m_gnt = p0_req ? 0 : 1;
                        if (m_gnt == 0) begin
                            m_addr = p0_addr; m_wdata = p0_wdata; m_we = p0_we;
                        end else begin
                            m_addr = p1_addr; m_wdata = p1_wdata; m_we = p1_we;
                        end
                        m_oor   = (m_addr >= 32'(DEPTH));
                        m_phase = 1;
                    end
                end
                1: begin
                    exp_rd[m_gnt] = (!m_oor && !m_we) ? ref_mem[m_addr[9:0]] : 32'h0;
                    if (!m_oor && m_we) ref_mem[m_addr[9:0]] = m_wdata;
                    m_phase = 2;
                end
                default: begin
                    m_last  = m_gnt;
                    m_phase = 0;
                end
            endcase
        end

        e_ack0 = (m_phase == 2 && m_gnt == 0);
        e_ack1 = (m_phase == 2 && m_gnt == 1);
        e_err  = (m_phase == 2 && m_oor);
        e_mw   = (m_phase == 1 && !m_oor && m_we);
        e_mr   = (m_phase == 1 && !m_oor && !m_we);
        check("p0_ack", 32'(p0_ack), 32'(e_ack0));
        check("p1_ack", 32'(p1_ack), 32'(e_ack1));
        check("err", 32'(err), 32'(e_err));
        check("mem_write", 32'(mem_write), 32'(e_mw));
        check("mem_read", 32'(mem_read), 32'(e_mr));
        if (m_phase == 1 && !m_oor) begin
            check("mem_addr", mem_addr, m_addr);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end else begin
            check("mem_addr_idle", mem_addr, 32'h0);
        end
        if (m_phase == 2) begin
            check("p0_rdata", p0_rdata, exp_rd[0]);
            check("p1_rdata", p1_rdata, exp_rd[1]);
        end

        saw_ack[0] = 1'b0;
        saw_ack[1] = 1'b0;
        if (p0_ack) begin
            saw_ack[0] = 1'b1; saw_rd[0] = p0_rdata; saw_err[0] = err;
            ack_order.push_back(0);
            $display("txn port=0 we=%0b addr=%h wdata=%h rdata=%h err=%0b t=%0t",
                     p0_we, p0_addr, p0_wdata, p0_rdata, err, $time);
            p0_req = 1'b0;
        end
        if (p1_ack) begin
            saw_ack[1] = 1'b1; saw_rd[1] = p1_rdata; saw_err[1] = err;
            ack_order.push_back(1);
            $display("txn port=1 we=%0b addr=%h wdata=%h rdata=%h err=%0b t=%0t",
                     p1_we, p1_addr, p1_wdata, p1_rdata, err, $time);
            p1_req = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 ? p0_req : p1_req) == 1'b0) begin
                if (mode == 1)
                    set_req(p, 1'b1, 32'($urandom_range(32, 63)), $urandom);
                else if (mode == 2 && $urandom_range(0, 3) == 0)
                    set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
        end
    endtask

    // Issue one access on a port and wait (bounded) for its ack.
    task automatic do_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat);
        bit done;
        set_req(p, we, a, d);
        rd = 32'h0; e = 1'b0; lat = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            lat = k + 1;
            if (saw_ack[p]) begin
                rd = saw_rd[p]; e = saw_err[p]; done = 1'b1;
            end
        end
        if (!done) begin
            check("txn_timeout", 32'(done), 32'h1);
            if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((p0_req || p1_req) && k < 40) begin
            cycle();
            k++;
        end
        check("drain_timeout", 32'(p0_req | p1_req), 32'h0);
        cycle();
    endtask

    task automatic wait_acks(input int n);
        int k;
        k = 0;
        while (ack_order.size() < n && k < 60) begin
            cycle();
            k++;
        end
        check("ack_count", 32'(ack_order.size() >= n), 32'h1);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = 32'h0;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Port 0 write then read back.
        do_txn(0, 1'b1, 32'd5, 32'hDEADBEEF, rd, e, lat);
        check("wr5_latency", 32'(lat), 32'd2);
        do_txn(0, 1'b0, 32'd5, 32'h0, rd, e, lat);
        check("rd5_data", rd, 32'hDEADBEEF);
        check("rd5_err", 32'(e), 32'h0);
        cycle();

        // Simultaneous continuous requests right after reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        ack_order.delete();
        mode = 1;
        set_req(0, 1'b1, 32'd40, 32'h11111111);
        set_req(1, 1'b1, 32'd41, 32'h22222222);
        wait_acks(4);
        mode = 0;
        if (ack_order.size() >= 4) begin
            check("order0", 32'(ack_order[0]), 32'd0);
            check("order1", 32'(ack_order[1]), 32'd1);
            check("order2", 32'(ack_order[2]), 32'd0);
            check("order3", 32'(ack_order[3]), 32'd1);
        end
        drain();

        // Out-of-range write, then boundary reads.
        do_txn(1, 1'b1, 32'd1024, 32'h1234, rd, e, lat);
        check("oor_err", 32'(e), 32'h1);
        do_txn(0, 1'b0, 32'd0, 32'h0, rd, e, lat);
        check("rd0_unchanged", rd, init_val(0));
        do_txn(0, 1'b0, 32'd1023, 32'h0, rd, e, lat);
        check("rd1023_data", rd, init_val(1023));
        check("rd1023_err", 32'(e), 32'h0);

        // Port 1 read of preloaded word; port 0 read data must hold.
        do_txn(1, 1'b0, 32'd7, 32'h0, rd, e, lat);
        check("rd7_data", rd, 32'hA5A5A5A5);
        check("p0_hold", p0_rdata, init_val(1023));
        cycle();

        // Reset on the edge that ends ACCESS of a write.
        set_req(0, 1'b1, 32'd9, 32'h55);
        cycle();
        check("rst_acc_mw", 32'(mem_write), 32'h1);
        rst = 1'b1;
        p0_req = 1'b0;
        cycle();
        rst = 1'b0;
        check("rst_acc_noack", 32'(p0_ack), 32'h0);
        ack_order.delete();
        set_req(0, 1'b0, 32'd9, 32'h0);
        set_req(1, 1'b0, 32'd7, 32'h0);
        wait_acks(1);
        if (ack_order.size() >= 1) check("post_rst_first", 32'(ack_order[0]), 32'd0);
        check("rd9_data", saw_rd[0], 32'h55);
        drain();

        // Reset during RESP: ack still visible, then port 0 favoured again.
        set_req(1, 1'b0, 32'd7, 32'h0);
        cycle();
        cycle();
        check("resp_ack_visible", 32'(p1_ack), 32'h1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("resp_rst_p1_rdata", p1_rdata, 32'h0);
        ack_order.delete();
        set_req(0, 1'b0, 32'd20, 32'h0);
        set_req(1, 1'b0, 32'd21, 32'h0);
        wait_acks(1);
        if (ack_order.size() >= 1) check("resp_rst_first", 32'(ack_order[0]), 32'd0);
        drain();

        // Random two-port traffic.
        mode = 2;
        repeat (600) cycle();
        mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
